// File: rtl/rgb_compare_pwm.sv
// Registered RGB comparison indicator: one colour channel per compare result,
// driven through a period-aligned PWM brightness stage with optional blink.
module rgb_compare_pwm #(
  parameter int WIDTH     = 4,
  parameter int PWM_BITS  = 8,
  parameter int BLINK_DIV = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                load,
  input  logic                clear,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [1:0]          mode,
  output logic                r,
  output logic                g,
  output logic                b_out
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_RED   = 2'd1,
    CLS_GREEN = 2'd2,
    CLS_BLUE  = 2'd3
  } cls_t;

  cls_t                cls_q, cls_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_act;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_ph;
  logic                pwm_wrap;
  logic                pwm_on;
  logic                en;

  function automatic cls_t classify(input logic [WIDTH-1:0] op_a,
                                    input logic [WIDTH-1:0] op_b);
    if (op_a > op_b)
      return CLS_RED;
    else if (op_a == op_b)
      return CLS_GREEN;
    else
      return CLS_BLUE;
  endfunction

  // Colour class register; clear has priority over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cls_q <= CLS_NONE;
    else
      cls_q <= cls_d;
  end

  always_comb begin
    cls_d = cls_q;
    if (clear)
      cls_d = CLS_NONE;
    else if (load)
      cls_d = classify(a, b);
  end

  assign pwm_wrap = (pwm_cnt == {PWM_BITS{1'b1}});

  // Timebase: free-running PWM counter, duty latched only at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_wrap)
        duty_act <= brightness;
    end
  end

  // Blink divider counts whole PWM periods; phase starts visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (pwm_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign pwm_on = (pwm_cnt < duty_act);

  always_comb begin
    en = 1'b0;
    case (mode)
      2'b00:   en = 1'b1;
      2'b01:   en = blink_ph;
      default: en = 1'b0;
    endcase
  end

  // Output stage: registered drives, mutually exclusive by class encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= 1'b0;
      g     <= 1'b0;
      b_out <= 1'b0;
    end else begin
      r     <= (cls_q == CLS_RED)   & pwm_on & en;
      g     <= (cls_q == CLS_GREEN) & pwm_on & en;
      b_out <= (cls_q == CLS_BLUE)  & pwm_on & en;
    end
  end

endmodule

// File: tb/tb_rgb_compare_pwm.sv
// Bench for rgb_compare_pwm (WIDTH=4, PWM_BITS=3, BLINK_DIV=2): a time-indexed
// reference model feeds a scoreboard queue, plus table and sequence checks.
module tb_rgb_compare_pwm;

  localparam int WIDTH     = 4;
  localparam int PWM_BITS  = 3;
  localparam int BLINK_DIV = 2;
  localparam int PERIOD    = 1 << PWM_BITS;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [WIDTH-1:0]    a = '0;
  logic [WIDTH-1:0]    b = '0;
  logic                load = 1'b0;
  logic                clear = 1'b0;
  logic [PWM_BITS-1:0] brightness = '0;
  logic [1:0]          mode = 2'b00;
  logic                r, g, b_out;

  rgb_compare_pwm #(
    .WIDTH(WIDTH), .PWM_BITS(PWM_BITS), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .load(load), .clear(clear),
    .brightness(brightness), .mode(mode), .r(r), .g(g), .b_out(b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic er;
    logic eg;
    logic eb;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    int               nr;
    int               ng;
    int               nb;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: time since reset release plus latched duty and class
  int n_m    = 0;
  int duty_m = 0;
  int cls_m  = 0;   // 0 none, 1 red, 2 green, 3 blue
  int cr = 0, cg = 0, cb = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    exp_t e, got;
    int   pc;
    bit   on, ph, en;
    pc = n_m % PERIOD;
    on = pc < duty_m;
    ph = (((n_m / PERIOD) / BLINK_DIV) % 2) == 0;
    en = (mode == 2'b00) ? 1'b1 : (mode == 2'b01) ? ph : 1'b0;
    e.er = (cls_m == 1) && on && en;
    e.eg = (cls_m == 2) && on && en;
    e.eb = (cls_m == 3) && on && en;
    q.push_back(e);
    @(posedge clk);
    if (pc == PERIOD - 1) duty_m = int'(brightness);
    if (clear) cls_m = 0;
    else if (load) cls_m = (a > b) ? 1 : (a == b) ? 2 : 3;
    n_m++;
    #1;
    if (q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      got = q.pop_front();
      check("sb_r", int'(r), int'(got.er));
      check("sb_g", int'(g), int'(got.eg));
      check("sb_b", int'(b_out), int'(got.eb));
    end
    check("onehot", int'($onehot0({r, g, b_out})), 1);
    cr += int'(r);
    cg += int'(g);
    cb += int'(b_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic zero_counts();
    cr = 0; cg = 0; cb = 0;
  endtask

  task automatic load_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    a = va; b = vb; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic align(input int modulus, input int phase);
    while ((n_m % modulus) != phase) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{4'd9,  4'd3,  7, 0, 0};
    tbl[1] = '{4'd5,  4'd5,  0, 7, 0};
    tbl[2] = '{4'd2,  4'd12, 0, 0, 7};
    tbl[3] = '{4'd15, 4'd0,  7, 0, 0};

    // Reset state and idle hold
    #12;
    check("reset_r", int'(r), 0);
    check("reset_g", int'(g), 0);
    check("reset_b", int'(b_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    zero_counts();
    run(20);
    check("idle_highs", cr + cg + cb, 0);

    // Compare classes at brightness 7, steady
    brightness = 3'd7;
    mode = 2'b00;
    run(2 * PERIOD);
    for (int i = 0; i < 4; i++) begin
      load_op(tbl[i].va, tbl[i].vb);
      zero_counts();
      run(PERIOD);
      check($sformatf("tbl%0d_r", i), cr, tbl[i].nr);
      check($sformatf("tbl%0d_g", i), cg, tbl[i].ng);
      check($sformatf("tbl%0d_b", i), cb, tbl[i].nb);
    end

    // Asynchronous reset mid-pulse (class red, duty 7)
    align(PERIOD, 2);
    check("pre_reset_r", int'(r), 1);
    rst_n = 1'b0;
    #1;
    check("async_r", int'(r), 0);
    check("async_pwm_cnt", int'(dut.pwm_cnt), 0);
    n_m = 0; duty_m = 0; cls_m = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Duty update alignment: 2 in the current period, 6 in the next
    load_op(4'd9, 4'd3);
    brightness = 3'd2;
    run(PERIOD);
    align(PERIOD, 0);
    zero_counts();
    run(3);
    brightness = 3'd6;
    run(PERIOD - 3);
    check("duty_cur_period", cr, 2);
    zero_counts();
    run(PERIOD);
    check("duty_next_period", cr, 6);
    brightness = 3'd0;
    run(PERIOD);
    zero_counts();
    run(2 * PERIOD);
    check("duty_zero", cr, 0);

    // Blink: green, duty 4, visible half then dark half
    load_op(4'd5, 4'd5);
    brightness = 3'd4;
    mode = 2'b01;
    run(PERIOD);
    align(2 * BLINK_DIV * PERIOD, 0);
    for (int k = 0; k < 2; k++) begin
      zero_counts();
      run(BLINK_DIV * PERIOD);
      check("blink_visible", cg, 8);
      zero_counts();
      run(BLINK_DIV * PERIOD);
      check("blink_dark", cg, 0);
    end

    // Forced off still honours load
    mode = 2'b10;
    zero_counts();
    run(5);
    load_op(4'd1, 4'd2);
    run(10);
    check("forced_off", cr + cg + cb, 0);
    mode = 2'b00;
    step();
    zero_counts();
    run(PERIOD);
    check("forced_off_load_blue", cb, 4);

    // load and clear together: clear wins
    a = 4'd10; b = 4'd1; load = 1'b1; clear = 1'b1;
    step();
    load = 1'b0; clear = 1'b0;
    zero_counts();
    run(PERIOD);
    check("clear_priority", cr + cg + cb, 0);

    // Random run against the model
    for (int i = 0; i < 500; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      load = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) brightness = PWM_BITS'($urandom);
      step();
    end
    load = 1'b0; clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
